// File: rtl/imm_pkg.sv
// -----------------------------------------------------------------------------
// imm_pkg
// Shared definitions for the immediate decode stage:
//   - RV32I major opcode constants
//   - fmt_e : 3-bit instruction format code carried with every stored entry
//   - xlen_ok() : datapath width legality check (32 or 64 only)
// -----------------------------------------------------------------------------
package imm_pkg;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } fmt_e;

    function automatic bit xlen_ok(input int xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

endpackage

// File: rtl/imm_extract.sv
// -----------------------------------------------------------------------------
// imm_extract
// Purely combinational RV32I format decode and immediate extraction.
// Ports:
//   instr_i : raw 32-bit instruction
//   imm_o   : immediate sign-extended from instr_i[31] to XLEN (0 for R/illegal)
//   fmt_o   : decoded format code
// -----------------------------------------------------------------------------
module imm_extract
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    output logic [XLEN-1:0] imm_o,
    output fmt_e            fmt_o
);

    logic [31:0] raw_imm;

    always_comb begin
        fmt_o = FMT_ILL;
        case (instr_i[6:0])
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: fmt_o = FMT_I;
            OP_STORE:                            fmt_o = FMT_S;
            OP_BRANCH:                           fmt_o = FMT_B;
            OP_LUI, OP_AUIPC:                    fmt_o = FMT_U;
            OP_JAL:                              fmt_o = FMT_J;
            OP_REG:                              fmt_o = FMT_R;
            default:                             fmt_o = FMT_ILL;
        endcase
    end

    // 32-bit immediate, already sign-extended to bit 31; widened below.
    always_comb begin
        raw_imm = '0;
        case (fmt_o)
            FMT_I: raw_imm = {{20{instr_i[31]}}, instr_i[31:20]};
            FMT_S: raw_imm = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            FMT_B: raw_imm = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                              instr_i[30:25], instr_i[11:8], 1'b0};
            FMT_U: raw_imm = {instr_i[31:12], 12'b0};
            FMT_J: raw_imm = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                              instr_i[20], instr_i[30:21], 1'b0};
            default: raw_imm = '0;
        endcase
    end

    // Bits above 31 replicate the sign; for R/illegal raw_imm is 0 so they are 0.
    for (genvar gi = 0; gi < XLEN; gi++) begin : g_ext
        if (gi < 32) begin : g_low
            assign imm_o[gi] = raw_imm[gi];
        end else begin : g_high
            assign imm_o[gi] = raw_imm[31];
        end
    end

endmodule

// File: rtl/imm_decode_stage.sv
// -----------------------------------------------------------------------------
// imm_decode_stage
// Single pipeline stage that decodes the instruction format and immediate of an
// RV32I instruction, buffered by an output register plus a skid register so that
// in_ready is registered and independent of out_ready.
// Optional feature macro: IMM_ILLEGAL_CNT_EN adds the saturating ill_cnt output.
// Ports:
//   clk, rst_n (async, active-low), flush (sync drop of held entries)
//   in_valid / in_ready / in_instr     : input handshake and instruction
//   out_valid / out_ready              : output handshake
//   out_instr / out_imm / out_fmt      : passthrough, immediate, format code
//   ill_cnt (IMM_ILLEGAL_CNT_EN only)  : accepted illegal-opcode count
// -----------------------------------------------------------------------------
module imm_decode_stage
    import imm_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int ILL_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic [XLEN-1:0]      out_imm,
    output logic [2:0]           out_fmt
`ifdef IMM_ILLEGAL_CNT_EN
    ,
    output logic [ILL_CNT_W-1:0] ill_cnt
`endif
);

    if (!xlen_ok(XLEN) || (ILL_CNT_W < 1)) begin : g_bad_param
        $error("imm_decode_stage: XLEN must be 32 or 64 and ILL_CNT_W >= 1");
    end

    logic [XLEN-1:0] dec_imm;
    fmt_e            dec_fmt;

    imm_extract #(.XLEN(XLEN)) u_extract (
        .instr_i (in_instr),
        .imm_o   (dec_imm),
        .fmt_o   (dec_fmt)
    );

    logic            out_v_q,     out_v_d;
    logic [31:0]     out_instr_q, out_instr_d;
    logic [XLEN-1:0] out_imm_q,   out_imm_d;
    fmt_e            out_fmt_q,   out_fmt_d;
    logic            skid_v_q,    skid_v_d;
    logic [31:0]     skid_instr_q, skid_instr_d;
    logic [XLEN-1:0] skid_imm_q,  skid_imm_d;
    fmt_e            skid_fmt_q,  skid_fmt_d;

    logic in_fire;
    logic out_slot_free;

    // Ready is purely the registered skid-empty flag.
    assign in_ready      = ~skid_v_q;
    assign in_fire       = in_valid & ~skid_v_q;
    assign out_slot_free = ~out_v_q | out_ready;

    always_comb begin
        out_v_d      = out_v_q;
        out_instr_d  = out_instr_q;
        out_imm_d    = out_imm_q;
        out_fmt_d    = out_fmt_q;
        skid_v_d     = skid_v_q;
        skid_instr_d = skid_instr_q;
        skid_imm_d   = skid_imm_q;
        skid_fmt_d   = skid_fmt_q;
        if (flush) begin
            out_v_d  = 1'b0;
            skid_v_d = 1'b0;
        end else if (out_slot_free) begin
            if (skid_v_q) begin
                // in_ready is low whenever the skid is full, so no input competes here.
                out_v_d     = 1'b1;
                out_instr_d = skid_instr_q;
                out_imm_d   = skid_imm_q;
                out_fmt_d   = skid_fmt_q;
                skid_v_d    = 1'b0;
            end else if (in_fire) begin
                out_v_d     = 1'b1;
                out_instr_d = in_instr;
                out_imm_d   = dec_imm;
                out_fmt_d   = dec_fmt;
            end else begin
                out_v_d     = 1'b0;
            end
        end else if (in_fire) begin
            skid_v_d     = 1'b1;
            skid_instr_d = in_instr;
            skid_imm_d   = dec_imm;
            skid_fmt_d   = dec_fmt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_v_q      <= 1'b0;
            out_instr_q  <= '0;
            out_imm_q    <= '0;
            out_fmt_q    <= FMT_R;
            skid_v_q     <= 1'b0;
            skid_instr_q <= '0;
            skid_imm_q   <= '0;
            skid_fmt_q   <= FMT_R;
        end else begin
            out_v_q      <= out_v_d;
            out_instr_q  <= out_instr_d;
            out_imm_q    <= out_imm_d;
            out_fmt_q    <= out_fmt_d;
            skid_v_q     <= skid_v_d;
            skid_instr_q <= skid_instr_d;
            skid_imm_q   <= skid_imm_d;
            skid_fmt_q   <= skid_fmt_d;
        end
    end

    assign out_valid = out_v_q;
    assign out_instr = out_instr_q;
    assign out_imm   = out_imm_q;
    assign out_fmt   = out_fmt_q;

`ifdef IMM_ILLEGAL_CNT_EN
    logic [ILL_CNT_W-1:0] ill_cnt_q, ill_cnt_d;

    always_comb begin
        ill_cnt_d = ill_cnt_q;
        if (in_fire && !flush && (dec_fmt == FMT_ILL) && (ill_cnt_q != '1)) begin
            ill_cnt_d = ill_cnt_q + ILL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ill_cnt_q <= '0;
        end else begin
            ill_cnt_q <= ill_cnt_d;
        end
    end

    assign ill_cnt = ill_cnt_q;
`endif

endmodule

// File: tb/tb_imm_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_imm_decode_stage
// Drives an XLEN=32 and an XLEN=64 instance from the same stimulus. A queue-level
// model (up to two held instructions, immediates computed with signed arithmetic)
// is compared against both instances on every falling edge; directed literal
// checks pin latency, immediates, backpressure, flush, reset and ill_cnt.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_imm_decode_stage;

    localparam int CW = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] in_instr = '0;

    logic        in_ready32, out_valid32, in_ready64, out_valid64;
    logic [31:0] out_instr32, out_instr64;
    logic [31:0] out_imm32;
    logic [63:0] out_imm64;
    logic [2:0]  out_fmt32, out_fmt64;
`ifdef IMM_ILLEGAL_CNT_EN
    logic [CW-1:0] ill_cnt32, ill_cnt64;
`endif

    int tests = 0;
    int fails = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    imm_decode_stage #(.XLEN(32), .ILL_CNT_W(CW)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32), .in_instr(in_instr),
        .out_valid(out_valid32), .out_ready(out_ready),
        .out_instr(out_instr32), .out_imm(out_imm32), .out_fmt(out_fmt32)
`ifdef IMM_ILLEGAL_CNT_EN
        , .ill_cnt(ill_cnt32)
`endif
    );

    imm_decode_stage #(.XLEN(64), .ILL_CNT_W(CW)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr),
        .out_valid(out_valid64), .out_ready(out_ready),
        .out_instr(out_instr64), .out_imm(out_imm64), .out_fmt(out_fmt64)
`ifdef IMM_ILLEGAL_CNT_EN
        , .ill_cnt(ill_cnt64)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int fmt_of(input logic [31:0] ins);
        case (ins[6:0])
            7'h13, 7'h03, 7'h67, 7'h73: return 1;
            7'h23:                      return 2;
            7'h63:                      return 3;
            7'h37, 7'h17:               return 4;
            7'h6F:                      return 5;
            7'h33:                      return 0;
            default:                    return 7;
        endcase
    endfunction

    function automatic logic [63:0] imm_of(input logic [31:0] ins);
        int     si;
        longint s;
        si = ins;
        s  = si;
        case (fmt_of(ins))
            1: return s >>> 20;
            2: return ((s >>> 25) <<< 5) | longint'(ins[11:7]);
            3: return ((s >>> 31) <<< 12) | (longint'(ins[7]) << 11)
                      | (longint'(ins[30:25]) << 5) | (longint'(ins[11:8]) << 1);
            4: return s & ~longint'(64'hFFF);
            5: return ((s >>> 31) <<< 20) | (longint'(ins[19:12]) << 12)
                      | (longint'(ins[20]) << 11) | (longint'(ins[30:21]) << 1);
            default: return 64'd0;
        endcase
    endfunction

    int          m_n = 0;
    logic [31:0] m_e0 = '0, m_e1 = '0;
    int          m_ill = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n   <= 0;
            m_ill <= 0;
        end else begin : upd
            int          n;
            logic [31:0] e0, e1;
            bit          acc;
            n   = m_n;
            e0  = m_e0;
            e1  = m_e1;
            acc = in_valid && (m_n < 2);
            if (flush) begin
                n = 0;
            end else begin
                if (n > 0 && out_ready) begin
                    e0 = e1;
                    n  = n - 1;
                end
                if (acc) begin
                    if (n == 0) e0 = in_instr;
                    else        e1 = in_instr;
                    n = n + 1;
                    if (fmt_of(in_instr) == 7 && m_ill < (1 << CW) - 1)
                        m_ill <= m_ill + 1;
                end
            end
            m_n  <= n;
            m_e0 <= e0;
            m_e1 <= e1;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            chk("mon_valid32", 64'(out_valid32), 64'(m_n > 0));
            chk("mon_valid64", 64'(out_valid64), 64'(m_n > 0));
            chk("mon_ready32", 64'(in_ready32), 64'(m_n < 2));
            chk("mon_ready64", 64'(in_ready64), 64'(m_n < 2));
            if (m_n > 0) begin
                chk("mon_instr32", 64'(out_instr32), 64'(m_e0));
                chk("mon_instr64", 64'(out_instr64), 64'(m_e0));
                chk("mon_imm32", 64'(out_imm32), 64'(imm_of(m_e0) & 64'hFFFF_FFFF));
                chk("mon_imm64", out_imm64, imm_of(m_e0));
                chk("mon_fmt32", 64'(out_fmt32), 64'(fmt_of(m_e0)));
                chk("mon_fmt64", 64'(out_fmt64), 64'(fmt_of(m_e0)));
            end
`ifdef IMM_ILLEGAL_CNT_EN
            chk("mon_ill32", 64'(ill_cnt32), 64'(m_ill));
            chk("mon_ill64", 64'(ill_cnt64), 64'(m_ill));
`endif
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic send_chk(input string name, input logic [31:0] ins,
                            input logic [63:0] exp_imm, input int exp_fmt);
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = ins;
        @(negedge clk);
        in_valid = 1'b0;
        chk({name, "_valid"}, 64'(out_valid32), 64'd1);
        chk({name, "_imm32"}, 64'(out_imm32), exp_imm & 64'hFFFF_FFFF);
        chk({name, "_imm64"}, out_imm64, exp_imm);
        chk({name, "_fmt"},   64'(out_fmt32), 64'(exp_fmt));
    endtask

    task automatic reset_pulse(input string name);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk({name, "_valid"}, 64'(out_valid32), 64'd0);
        chk({name, "_ready"}, 64'(in_ready32), 64'd1);
        chk({name, "_instr"}, 64'(out_instr32), 64'd0);
        chk({name, "_imm64"}, out_imm64, 64'd0);
        chk({name, "_fmt"},   64'(out_fmt32), 64'd0);
`ifdef IMM_ILLEGAL_CNT_EN
        chk({name, "_ill"},   64'(ill_cnt32), 64'd0);
`endif
    endtask

    logic [31:0] tbl [8] = '{32'hFFF00093, 32'hFE112E23, 32'h123450B7, 32'hFF9FF06F,
                              32'hFE000EE3, 32'h002081B3, 32'h00000000, 32'h800000B7};

    initial begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst_valid", 64'(out_valid32), 64'd0);
        chk("rst_ready", 64'(in_ready32), 64'd1);
        chk("rst_imm",   64'(out_imm32), 64'd0);
        chk("rst_fmt",   64'(out_fmt32), 64'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        send_chk("addi", 32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        send_chk("sw",   32'hFE112E23, 64'hFFFF_FFFF_FFFF_FFFC, 2);
        send_chk("lui",  32'h123450B7, 64'h0000_0000_1234_5000, 4);
        send_chk("jal",  32'hFF9FF06F, 64'hFFFF_FFFF_FFFF_FFF8, 5);
        send_chk("luin", 32'h800000B7, 64'hFFFF_FFFF_8000_0000, 4);
        send_chk("beq",  32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, 3);
        send_chk("add",  32'h002081B3, 64'd0, 0);
        send_chk("ill",  32'h00000000, 64'd0, 7);

        // Reset with both registers full, then accept on the first edge after release.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00100093;
        @(negedge clk);
        in_instr  = 32'h00200093;
        reset_pulse("rst_mid");
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        in_instr  = 32'h123450B7;
        @(negedge clk);
        in_valid  = 1'b0;
        chk("post_rst_valid", 64'(out_valid32), 64'd1);
        chk("post_rst_instr", 64'(out_instr32), 64'h123450B7);

        // Five illegal opcodes back to back; counter saturates at 3.
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = 32'h00000000;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 5) in_valid = 1'b0;
`ifdef IMM_ILLEGAL_CNT_EN
            chk("ill_cnt_seq", 64'(ill_cnt32), 64'((k > 3) ? 3 : k));
`endif
            chk("ill_fmt", 64'(out_fmt32), 64'd7);
            chk("ill_imm", out_imm64, 64'd0);
        end
        reset_pulse("rst_ill");
        @(negedge clk);
        rst_n = 1'b1;

        // Backpressure: three offered, two accepted, drained in order.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00A00093;
        @(negedge clk);
        chk("bp_ready_c1", 64'(in_ready32), 64'd1);
        in_instr  = 32'h00B00093;
        @(negedge clk);
        chk("bp_ready_c2", 64'(in_ready32), 64'd0);
        in_instr  = 32'h00C00093;
        @(negedge clk);
        in_valid  = 1'b0;
        chk("bp_ready_c3", 64'(in_ready32), 64'd0);
        chk("bp_hold",     64'(out_instr32), 64'h00A00093);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_second",   64'(out_instr32), 64'h00B00093);
        chk("bp_valid2",   64'(out_valid32), 64'd1);
        chk("bp_ready_up", 64'(in_ready32), 64'd1);
        @(negedge clk);
        chk("bp_empty",    64'(out_valid32), 64'd0);

        // Flush with both registers full and input presented.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00D00093;
        @(negedge clk);
        in_instr  = 32'h00E00093;
        @(negedge clk);
        chk("fl_full", 64'(in_ready32), 64'd0);
        in_instr  = 32'h00F00093;
        flush     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        flush     = 1'b0;
        in_valid  = 1'b0;
        chk("fl_valid", 64'(out_valid32), 64'd0);
        chk("fl_ready", 64'(in_ready32), 64'd1);
        @(negedge clk);
        chk("fl_gone", 64'(out_valid32), 64'd0);

        // Flush while in_ready is high: the presented input is discarded.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h01000093;
        @(negedge clk);
        in_instr  = 32'h01100093;
        flush     = 1'b1;
        @(negedge clk);
        flush     = 1'b0;
        in_valid  = 1'b0;
        chk("fl2_valid", 64'(out_valid32), 64'd0);
        chk("fl2_ready", 64'(in_ready32), 64'd1);
        @(negedge clk);
        chk("fl2_gone", 64'(out_valid32), 64'd0);

        // Mixed stream under varying backpressure, checked by the model.
        for (int i = 0; i < 32; i++) begin
            in_valid  = (i % 4) != 3;
            in_instr  = tbl[i % 8] ^ {24'(i), 8'h00};
            out_ready = (i % 3) != 1;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("drain_empty", 64'(out_valid32), 64'd0);

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/imm_decode_stage.md
IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width; SHALL accept 32 or 64 only.
REQ-002 Parameter ILL_CNT_W, default 16, width of illegal-opcode counter.
REQ-003 Port clk, input, 1, single clock; all state on rising edge.
REQ-004 Port rst_n, input, 1, reset, asynchronous, active-low.
REQ-005 Port flush, input, 1, synchronous drop of all held entries.
REQ-006 Port in_valid, input, 1, instruction present.
REQ-007 Port in_ready, output, 1, stage can accept this cycle.
REQ-008 Port in_instr, input, 32, raw RV32I instruction.
REQ-009 Port out_valid, output, 1, decoded entry present.
REQ-010 Port out_ready, input, 1, consumer accepts this cycle.
REQ-011 Port out_instr, output, 32, instruction passthrough.
REQ-012 Port out_imm, output, XLEN, sign-extended immediate.
REQ-013 Port out_fmt, output, 3, format code: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 7 illegal.
REQ-014 Port ill_cnt, output, ILL_CNT_W, illegal-opcode count; present only when IMM_ILLEGAL_CNT_EN is defined.

Function
REQ-015 Opcode in_instr[6:0] SHALL map: 0010011/0000011/1100111/1110011 to I, 0100011 to S, 1100011 to B, 0110111/0010111 to U, 1101111 to J, 0110011 to R, and any other value to illegal.
REQ-016 I imm = instr[31:20]; S = {instr[31:25],instr[11:7]}; B = {instr[31],instr[7],instr[30:25],instr[11:8],0}; U = {instr[31:12],12'b0}; J = {instr[31],instr[19:12],instr[20],instr[30:21],0}.
REQ-017 All formats SHALL be sign-extended from instr[31] to XLEN; R and illegal SHALL yield out_imm = 0.
REQ-018 Transfer SHALL occur at input when in_valid&&in_ready, and at output when out_valid&&out_ready.
REQ-019 Storage SHALL be one output register plus one skid register; latency in_valid to out_valid SHALL be exactly 1 cycle when the skid register is empty.
REQ-020 in_ready SHALL be a registered signal equal to "skid register empty"; it SHALL NOT depend combinationally on out_ready.
REQ-021 An accepted entry SHALL go to the output register if it is empty or being drained that cycle, otherwise to the skid register.
REQ-022 When the output drains and the skid register is full, the skid entry SHALL move to the output register in the same edge and in_ready SHALL rise next cycle.
REQ-023 Order SHALL be preserved; no entry SHALL be dropped or duplicated except by flush.
REQ-024 flush SHALL clear both valids at the next edge and win over same-cycle input and output transfers; an input presented with flush is discarded.
REQ-025 out_instr, out_imm and out_fmt SHALL hold stable while out_valid&&!out_ready.

Reset
REQ-026 Assertion of rst_n low SHALL immediately clear out_valid, the skid valid and ill_cnt, and SHALL force in_ready to 1 and out_imm, out_instr and out_fmt to 0.
REQ-027 Reset mid-transfer SHALL discard all held entries; the first edge after deassertion SHALL accept input normally.

Configuration
REQ-028 With macro IMM_ILLEGAL_CNT_EN defined, ill_cnt SHALL increment by 1 per accepted, non-flushed illegal-format instruction and saturate at all-ones.
REQ-029 Without IMM_ILLEGAL_CNT_EN, the ill_cnt port and counter SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-030 Package imm_pkg SHALL hold the opcode constants, the 3-bit format enum, and the XLEN legality check.
REQ-031 The combinational format decode and extension SHALL be the sub-module imm_extract, instanced once at the input; stored entries SHALL carry the decoded imm and fmt.

Verification
REQ-032 XLEN=32: 0xFFF00093 (addi x1,x0,-1) -> one cycle later out_imm=0xFFFFFFFF, out_fmt=1.
REQ-033 0xFE112E23 (sw x1,-4(x2)) -> out_imm=0xFFFFFFFC, fmt=2; 0x123450B7 (lui) -> 0x12345000, fmt=4; 0xFF9FF06F (jal x0,-8) -> 0xFFFFFFF8, fmt=5.
REQ-034 XLEN=64, 0x123450B7 -> out_imm=0x0000000012345000; 0x800000B7 -> 0xFFFFFFFF80000000.
REQ-035 Backpressure: hold out_ready=0, send 3 back-to-back entries -> 2 accepted, in_ready=0 from the second cycle; release -> both emerge in order and in_ready returns to 1.
REQ-036 Flush with in_valid=1 and both registers full -> next cycle out_valid=0, in_ready=1, and the flushed input never appears.
REQ-037 IMM_ILLEGAL_CNT_EN, ILL_CNT_W=2: 5 accepted opcodes 0000000 -> ill_cnt sequence 1,2,3,3,3 with out_fmt=7 and out_imm=0 on each; rst_n pulse mid-stream -> ill_cnt=0 immediately.
